// File: rtl/placar_pkg.sv
// Shared definitions for the scoreboard game controller: FSM encoding, game limits
// and the score-range check applied before a point command is issued.
package placar_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUNNING = 2'b01,
        ST_PAUSED  = 2'b10,
        ST_END     = 2'b11
    } estado_t;

    typedef logic [1:0] pontos_t;

    localparam int MAX_PONTOS  = 99;
    localparam int NUM_QUARTOS = 4;

    // True when applying the command keeps the score inside 0..MAX_PONTOS.
    function automatic logic pontos_validos(input logic [6:0] placar,
                                            input pontos_t    pontos,
                                            input logic       sub);
        logic [7:0] soma;
        soma = {1'b0, placar} + {6'd0, pontos};
        if (sub)
            return {5'd0, pontos} <= placar;
        else
            return soma <= 8'(MAX_PONTOS);
    endfunction

endpackage

// File: rtl/detector_botao.sv
// Per-team point button: 00->nonzero edge detection and a one-deep pending latch.
// A new press may reload the latch in the same cycle the old one is consumed.
module detector_botao
    import placar_pkg::*;
(
    input  logic    clock,
    input  logic    clr,
    input  pontos_t btns,
    input  logic    habilita,
    input  logic    consome,
    input  logic    descarta,
    output logic    pendente,
    output pontos_t codigo
);

    pontos_t anterior;
    logic    press;

    assign press = habilita && (btns != 2'b00) && (anterior == 2'b00);

    always_ff @(posedge clock or posedge clr) begin
        if (clr) begin
            anterior <= 2'b00;
            pendente <= 1'b0;
            codigo   <= 2'b00;
        end else begin
            anterior <= btns;
            if (descarta) begin
                pendente <= 1'b0;
            end else if (press && (!pendente || consome)) begin
                pendente <= 1'b1;
                codigo   <= btns;
            end else if (consome) begin
                pendente <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/controle_jogo.sv
// Game controller: start/pause FSM, quarter counter and arbitration of team point
// presses into one-cycle score commands (team 1 wins ties, out-of-range ones dropped).
module controle_jogo
    import placar_pkg::*;
(
    input  logic       clock,
    input  logic       clr,
    input  logic       btnIniciar,
    input  logic [1:0] btnsT1,
    input  logic [1:0] btnsT2,
    input  logic       chaveNP,
    input  logic       fimQuarto,
    input  logic [6:0] placarT1,
    input  logic [6:0] placarT2,
    output logic [1:0] somaBTNsT1,
    output logic [1:0] somaBTNsT2,
    output logic       modoSub,
    output logic       clrPlacar,
    output logic [1:0] quarto,
    output logic [1:0] estado
);

    estado_t st, st_nxt;
    logic    ini_ant, ini_borda;
    logic    ultimo, rodando, flush, novo_jogo, avanca, pode_emitir;
    logic    pend1, pend2, cons1, cons2;
    pontos_t cod1, cod2;

    assign ini_borda = btnIniciar && !ini_ant;
    assign ultimo    = (quarto == 2'(NUM_QUARTOS - 1));

    always_ff @(posedge clock or posedge clr) begin
        if (clr)
            st <= ST_IDLE;
        else
            st <= st_nxt;
    end

    // End of quarter outranks a simultaneous start/pause press.
    always_comb begin
        st_nxt = st;
        case (st)
            ST_IDLE:    if (ini_borda) st_nxt = ST_RUNNING;
            ST_RUNNING: begin
                if (fimQuarto)
                    st_nxt = ultimo ? ST_END : ST_PAUSED;
                else if (ini_borda)
                    st_nxt = ST_PAUSED;
            end
            ST_PAUSED:  if (ini_borda) st_nxt = ST_RUNNING;
            ST_END:     if (ini_borda) st_nxt = ST_IDLE;
            default:    st_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        estado      = st;
        rodando     = (st == ST_RUNNING);
        flush       = rodando && (st_nxt != ST_RUNNING);
        novo_jogo   = (st == ST_END) && ini_borda;
        avanca      = rodando && fimQuarto && !ultimo;
        pode_emitir = rodando && !flush;
        cons1       = pode_emitir && pend1;
        cons2       = pode_emitir && pend2 && !pend1;
    end

    detector_botao u_det_t1 (
        .clock    (clock),
        .clr      (clr),
        .btns     (btnsT1),
        .habilita (rodando),
        .consome  (cons1),
        .descarta (flush),
        .pendente (pend1),
        .codigo   (cod1)
    );

    detector_botao u_det_t2 (
        .clock    (clock),
        .clr      (clr),
        .btns     (btnsT2),
        .habilita (rodando),
        .consome  (cons2),
        .descarta (flush),
        .pendente (pend2),
        .codigo   (cod2)
    );

    // A consumed press that would leave the score out of range produces no pulse.
    always_ff @(posedge clock or posedge clr) begin
        if (clr) begin
            ini_ant    <= 1'b0;
            somaBTNsT1 <= 2'b00;
            somaBTNsT2 <= 2'b00;
            modoSub    <= 1'b0;
            clrPlacar  <= 1'b0;
            quarto     <= 2'b00;
        end else begin
            ini_ant    <= btnIniciar;
            somaBTNsT1 <= (cons1 && pontos_validos(placarT1, cod1, chaveNP)) ? cod1 : 2'b00;
            somaBTNsT2 <= (cons2 && pontos_validos(placarT2, cod2, chaveNP)) ? cod2 : 2'b00;
            modoSub    <= chaveNP;
            clrPlacar  <= novo_jogo;
            if (novo_jogo)
                quarto <= 2'b00;
            else if (avanca)
                quarto <= quarto + 2'b01;
        end
    end

endmodule

// File: tb/tb_controle_jogo.sv
// Bench for controle_jogo: directed game scenarios followed by random play, every
// cycle compared against a queue-based behavioural model of the game rules.
module tb_controle_jogo;

    logic       clock = 1'b0;
    logic       clr;
    logic       btnIniciar;
    logic [1:0] btnsT1, btnsT2;
    logic       chaveNP, fimQuarto;
    logic [6:0] placarT1, placarT2;
    logic [1:0] somaBTNsT1, somaBTNsT2;
    logic       modoSub, clrPlacar;
    logic [1:0] quarto, estado;

    controle_jogo dut (
        .clock      (clock),
        .clr        (clr),
        .btnIniciar (btnIniciar),
        .btnsT1     (btnsT1),
        .btnsT2     (btnsT2),
        .chaveNP    (chaveNP),
        .fimQuarto  (fimQuarto),
        .placarT1   (placarT1),
        .placarT2   (placarT2),
        .somaBTNsT1 (somaBTNsT1),
        .somaBTNsT2 (somaBTNsT2),
        .modoSub    (modoSub),
        .clrPlacar  (clrPlacar),
        .quarto     (quarto),
        .estado     (estado)
    );

    always #5 clock = ~clock;

    int vetores = 0;
    int erros   = 0;

    // Game phases: 0 idle, 1 running, 2 paused, 3 end.
    int m_st, m_q, m_s1, m_s2, m_sub, m_clrp;
    int p_ini, p_t1, p_t2;
    int fila_time[$];
    int fila_pts[$];

    task automatic chk(input string tag, input int got, input int exp);
        vetores++;
        if (got != exp) begin
            erros++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_q = 0; m_s1 = 0; m_s2 = 0; m_sub = 0; m_clrp = 0;
        p_ini = 0; p_t1 = 0; p_t2 = 0;
        fila_time.delete();
        fila_pts.delete();
    endtask

    function automatic bit na_fila(input int team);
        foreach (fila_time[i])
            if (fila_time[i] == team) return 1'b1;
        return 1'b0;
    endfunction

    // One clock edge of the game rules, using the inputs present at that edge.
    task automatic model_edge();
        int  nxt, team, pts, pl;
        bit  e_ini, pr1, pr2, ok;
        e_ini = btnIniciar && (p_ini == 0);
        pr1   = (m_st == 1) && (btnsT1 != 0) && (p_t1 == 0);
        pr2   = (m_st == 1) && (btnsT2 != 0) && (p_t2 == 0);
        p_ini = int'(btnIniciar);
        p_t1  = int'(btnsT1);
        p_t2  = int'(btnsT2);
        m_s1 = 0; m_s2 = 0; m_clrp = 0;
        m_sub = int'(chaveNP);
        nxt = m_st;
        case (m_st)
            0: if (e_ini) nxt = 1;
            1: begin
                if (fimQuarto) begin
                    if (m_q == 3) nxt = 3;
                    else begin nxt = 2; m_q++; end
                end else if (e_ini) nxt = 2;
            end
            2: if (e_ini) nxt = 1;
            default: if (e_ini) begin nxt = 0; m_q = 0; m_clrp = 1; end
        endcase
        if (m_st == 1) begin
            if (nxt != 1) begin
                fila_time.delete();
                fila_pts.delete();
            end else begin
                if (fila_time.size() > 0) begin
                    team = fila_time.pop_front();
                    pts  = fila_pts.pop_front();
                    pl   = (team == 1) ? int'(placarT1) : int'(placarT2);
                    ok   = chaveNP ? (pts <= pl) : (pl + pts <= 99);
                    if (ok) begin
                        if (team == 1) m_s1 = pts; else m_s2 = pts;
                    end
                end
                if (pr1 && !na_fila(1)) begin fila_time.push_back(1); fila_pts.push_back(int'(btnsT1)); end
                if (pr2 && !na_fila(2)) begin fila_time.push_back(2); fila_pts.push_back(int'(btnsT2)); end
            end
        end
        m_st = nxt;
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ".estado"},     int'(estado),     m_st);
        chk({ctx, ".quarto"},     int'(quarto),     m_q);
        chk({ctx, ".somaBTNsT1"}, int'(somaBTNsT1), m_s1);
        chk({ctx, ".somaBTNsT2"}, int'(somaBTNsT2), m_s2);
        chk({ctx, ".modoSub"},    int'(modoSub),    m_sub);
        chk({ctx, ".clrPlacar"},  int'(clrPlacar),  m_clrp);
    endtask

    task automatic step(input string ctx);
        @(posedge clock);
        if (clr) model_reset();
        else     model_edge();
        #1;
        check_all(ctx);
    endtask

    task automatic press_ini(input string ctx);
        btnIniciar = 1'b1;
        step(ctx);
        btnIniciar = 1'b0;
        step(ctx);
    endtask

    initial begin
        clr = 1'b1; btnIniciar = 1'b0; btnsT1 = 2'b00; btnsT2 = 2'b00;
        chaveNP = 1'b0; fimQuarto = 1'b0; placarT1 = 7'd0; placarT2 = 7'd0;
        model_reset();
        #1;
        check_all("reset");
        step("reset");
        step("reset");
        clr = 1'b0;
        step("idle");

        // Single held press, 2 points, added to a score of 5.
        press_ini("start");
        placarT1 = 7'd5; btnsT1 = 2'b10;
        repeat (3) step("held_t1");
        btnsT1 = 2'b00;
        repeat (2) step("held_t1_rel");

        // Simultaneous presses: team 1 first, team 2 one cycle later.
        placarT2 = 7'd40; btnsT1 = 2'b11; btnsT2 = 2'b01;
        repeat (4) step("both");
        btnsT1 = 2'b00; btnsT2 = 2'b00;
        step("both_rel");

        // Out-of-range commands are consumed silently.
        placarT2 = 7'd98; btnsT2 = 2'b10;
        repeat (3) step("sat_add");
        btnsT2 = 2'b00;
        placarT1 = 7'd1; chaveNP = 1'b1; btnsT1 = 2'b10;
        repeat (3) step("sat_sub");
        btnsT1 = 2'b00; chaveNP = 1'b0;
        step("sat_rel");

        // Four quarters, then a new game.
        for (int i = 0; i < 4; i++) begin
            fimQuarto = 1'b1;
            step("quarter");
            fimQuarto = 1'b0;
            step("quarter");
            press_ini("quarter_ini");
        end
        repeat (2) step("new_game");

        // Press while paused, then async clear with a press in flight.
        press_ini("restart");
        press_ini("pause");
        btnsT1 = 2'b11;
        repeat (2) step("paused_press");
        btnsT1 = 2'b00;
        step("paused_rel");
        press_ini("resume");
        btnsT1 = 2'b01; chaveNP = 1'b1;
        step("pre_clr");
        clr = 1'b1;
        #1;
        model_reset();
        check_all("clr_async");
        step("clr_hold");
        btnsT1 = 2'b00; chaveNP = 1'b0; clr = 1'b0;
        repeat (3) step("clr_release");

        // Random play.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 11) == 0) btnIniciar = ~btnIniciar;
            if ($urandom_range(0, 3) == 0)
                btnsT1 = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            if ($urandom_range(0, 3) == 0)
                btnsT2 = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) chaveNP = ~chaveNP;
            fimQuarto = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 15) == 0) placarT1 = 7'($urandom_range(0, 99));
            if ($urandom_range(0, 15) == 0)
                placarT2 = ($urandom_range(0, 1) == 0) ? 7'($urandom_range(0, 3)) : 7'($urandom_range(95, 99));
            clr = ($urandom_range(0, 399) == 0);
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
        $finish;
    end

endmodule

// File: doc/controle_jogo.md
CONTROLE_JOGO -- requirements
Module: controle_jogo

Interface
REQ-001 SHALL have port clock, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port clr, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port btnIniciar, input, 1 bit: start/pause/new-game button, level input, acted on at its rising edge.
REQ-004 SHALL have port btnsT1, input, 2 bits: team 1 point code; 00 none, 01/10/11 = 1/2/3 points.
REQ-005 SHALL have port btnsT2, input, 2 bits: team 2 point code, same encoding as btnsT1.
REQ-006 SHALL have port chaveNP, input, 1 bit: 0 add, 1 subtract; sampled at issue cycle.
REQ-007 SHALL have port fimQuarto, input, 1 bit: one-cycle pulse from the game timer at end of quarter.
REQ-008 SHALL have port placarT1, input, 7 bits: team 1 current score fed back from its datapath.
REQ-009 SHALL have port placarT2, input, 7 bits: team 2 current score fed back from its datapath.
REQ-010 SHALL have port somaBTNsT1, output, 2 bits: one-cycle point command to team 1 datapath; 00 idle.
REQ-011 SHALL have port somaBTNsT2, output, 2 bits: one-cycle point command to team 2 datapath; 00 idle.
REQ-012 SHALL have port modoSub, output, 1 bit: registered copy of chaveNP, valid with any nonzero command.
REQ-013 SHALL have port clrPlacar, output, 1 bit: one-cycle pulse that clears both score registers.
REQ-014 SHALL have port quarto, output, 2 bits: current quarter minus 1 (0..3).
REQ-015 SHALL have port estado, output, 2 bits: FSM state.

Function
REQ-016 SHALL implement FSM states IDLE=00, RUNNING=01, PAUSED=10, END=11.
REQ-017 SHALL apply these transitions on a btnIniciar rising edge: IDLE->RUNNING, RUNNING->PAUSED, PAUSED->RUNNING.
REQ-018 SHALL, on btnIniciar rising edge in END, go to IDLE, set quarto=0, and pulse clrPlacar for exactly one cycle.
REQ-019 SHALL, on fimQuarto in RUNNING, go to END if quarto==3; otherwise increment quarto and go to PAUSED.
REQ-020 SHALL give fimQuarto priority over a same-cycle btnIniciar edge in RUNNING; the btnIniciar edge is discarded.
REQ-021 SHALL ignore fimQuarto in IDLE, PAUSED and END.
REQ-022 SHALL register a press only in RUNNING, at the first edge where the team code is nonzero and the previous sample was 00; the code is latched as pending.
REQ-023 SHALL ignore further codes from that team until its input returns to 00; a pending press is not overwritten.
REQ-024 SHALL issue a command the cycle after a press is registered (latency 1), asserted for exactly one cycle.
REQ-025 SHALL, when both teams are pending in the same cycle, issue team 1 first and team 2 on the next cycle; at most one command is nonzero per cycle.
REQ-026 SHALL suppress, without a pulse, an add command if placar+points>99, and a subtract command if points>placar; a suppressed press is consumed.
REQ-027 SHALL flush all pending presses when leaving RUNNING.

Reset
REQ-028 SHALL, while clr=1, force estado=IDLE, quarto=0, somaBTNsT1=somaBTNsT2=00, modoSub=0, clrPlacar=0, clear pending and edge registers, immediately and independent of clock.
REQ-029 SHALL, on reset mid-operation, discard in-flight commands without emitting them after release.

Structure
REQ-030 SHALL take state encodings, MAX_PONTOS=99 and NUM_QUARTOS=4 from a shared package placar_pkg.
REQ-031 SHALL instantiate sub-module detector_botao (edge detect plus one-deep pending latch) once per team.

Verification
REQ-032 SHALL cover: clr, btnIniciar edge, btnsT1=10 held 3 cycles with placarT1=5, chaveNP=0 -> somaBTNsT1=10 for one cycle, one cycle after detection; no repeat.
REQ-033 SHALL cover: btnsT1=11 and btnsT2=01 rising in the same cycle -> somaBTNsT1=11 at cycle N, then somaBTNsT2=01 at cycle N+1.
REQ-034 SHALL cover: placarT2=98, btnsT2=10 add -> no pulse; placarT1=1, chaveNP=1, btnsT1=10 -> no pulse.
REQ-035 SHALL cover: four fimQuarto pulses, each followed by a btnIniciar edge -> quarto steps 0,1,2,3, then estado=END; next btnIniciar edge -> IDLE, clrPlacar one-cycle pulse, quarto=0.
REQ-036 SHALL cover: press in PAUSED -> no command; clr asserted mid-RUNNING with a pending press -> all outputs 0 and no command after release.
